step_phase_decoder: RTL and testbench

- Receive-side counterpart of the stepper drive. Watches the four coil lines {A1,B1,A2,B2}, decodes the phase sequence and keeps a signed step position with direction.
- Flags illegal codes and skipped phases. Reports motion/idle status.
- Sits on the motor-side pins, either looped back from the driver outputs or on a monitor header. Lets the controller confirm that commanded moves happened.

---
 rtl/step_phase_decoder.sv | 226 ++++++++++++++++++++++
 tb/tb_step_phase_decoder.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_phase_decoder.sv
`default_nettype none
// ============================================================================
// Module      : step_phase_decoder
// Description : Watches the four stepper coil lines, filters and decodes the
//               full-step phase sequence, and keeps a signed step position,
//               direction, motion/idle status and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module step_phase_decoder #(
    parameter int POS_W       = 14,
    parameter int FILT_CYCLES = 4,
    parameter int IDLE_CYCLES = 2000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    A1,
    input  logic                    B1,
    input  logic                    A2,
    input  logic                    B2,
    input  logic                    clear_pos,
    input  logic                    clear_err,
    output logic signed [POS_W-1:0] position,
    output logic                    dir,
    output logic                    step_pulse,
    output logic                    moving,
    output logic                    idle,
    output logic                    err_illegal,
    output logic                    err_skip
);

    localparam logic [7:0]          c_FILT     = 8'(FILT_CYCLES);
    localparam int                  c_IDLE_W   = $clog2(IDLE_CYCLES + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(IDLE_CYCLES);
    localparam logic [POS_W-1:0]    c_ONE      = POS_W'(1);

    // Coil codes, ordered {A1,B1,A2,B2}
    localparam logic [3:0] c_OFF = 4'b0000;
    localparam logic [3:0] c_P1  = 4'b1100;
    localparam logic [3:0] c_P2  = 4'b0110;
    localparam logic [3:0] c_P3  = 4'b0011;
    localparam logic [3:0] c_P4  = 4'b1001;

    typedef enum logic [2:0] {
        ST_UNK = 3'd0,
        ST_OFF = 3'd1,
        ST_P1  = 3'd2,
        ST_P2  = 3'd3,
        ST_P3  = 3'd4,
        ST_P4  = 3'd5
    } state_t;

    logic [3:0]          r_sync1;
    logic [3:0]          r_sync2;
    logic [3:0]          r_cand;
    logic [7:0]          r_filt_cnt;
    logic [3:0]          r_acc;
    logic                r_chg;
    state_t              r_state;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic                r_stepped;

    logic [7:0]          w_filt_next;
    logic                w_accept;
    logic                w_new_valid;
    logic [1:0]          w_new_idx;
    logic                w_cur_valid;
    logic [1:0]          w_cur_idx;
    logic [1:0]          w_delta;
    state_t              w_state_next;
    logic                w_step_fwd;
    logic                w_step_rev;
    logic                w_set_skip;
    logic                w_set_illegal;
    logic [POS_W-1:0]    w_pos_base;

    // Two-flop synchronizer on the asynchronous coil lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= {A1, B1, A2, B2};
            r_sync2 <= r_sync1;
        end
    end

    // Run length of the synchronized code (saturating); accept on reaching the threshold
    always_comb begin
        w_filt_next = 8'd1;
        if (r_sync2 == r_cand) begin
            w_filt_next = (r_filt_cnt == c_FILT) ? r_filt_cnt : r_filt_cnt + 8'd1;
        end
        w_accept = (w_filt_next == c_FILT) && (r_sync2 != r_acc);
    end

    // Glitch filter registers, accepted code and its one-cycle change strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cand     <= 4'b0000;
            r_filt_cnt <= 8'd0;
            r_acc      <= 4'b0000;
            r_chg      <= 1'b0;
        end else begin
            r_cand     <= r_sync2;
            r_filt_cnt <= w_filt_next;
            r_chg      <= w_accept;
            if (w_accept) begin
                r_acc <= r_sync2;
            end
        end
    end

    // Phase index of the accepted code (P1..P4 -> 0..3)
    always_comb begin
        w_new_valid = 1'b1;
        w_new_idx   = 2'd0;
        case (r_acc)
            c_P1:    w_new_idx = 2'd0;
            c_P2:    w_new_idx = 2'd1;
            c_P3:    w_new_idx = 2'd2;
            c_P4:    w_new_idx = 2'd3;
            default: w_new_valid = 1'b0;
        endcase
    end

    // Phase index of the tracker state; UNK and OFF carry no phase
    always_comb begin
        w_cur_valid = 1'b1;
        w_cur_idx   = 2'd0;
        case (r_state)
            ST_P1:   w_cur_idx = 2'd0;
            ST_P2:   w_cur_idx = 2'd1;
            ST_P3:   w_cur_idx = 2'd2;
            ST_P4:   w_cur_idx = 2'd3;
            default: w_cur_valid = 1'b0;
        endcase
    end

    // Tracker next state and step/error events, evaluated only on an accepted change
    always_comb begin
        w_state_next  = r_state;
        w_step_fwd    = 1'b0;
        w_step_rev    = 1'b0;
        w_set_skip    = 1'b0;
        w_set_illegal = 1'b0;
        w_delta       = w_new_idx - w_cur_idx;
        if (r_chg) begin
            if (r_acc == c_OFF) begin
                w_state_next = ST_OFF;
            end else if (!w_new_valid) begin
                // Illegal code: the next legal phase restarts tracking from scratch
                w_set_illegal = 1'b1;
                w_state_next  = ST_UNK;
            end else begin
                case (w_new_idx)
                    2'd0:    w_state_next = ST_P1;
                    2'd1:    w_state_next = ST_P2;
                    2'd2:    w_state_next = ST_P3;
                    default: w_state_next = ST_P4;
                endcase
                if (w_cur_valid) begin
                    case (w_delta)
                        2'd1:    w_step_fwd = 1'b1;
                        2'd3:    w_step_rev = 1'b1;
                        2'd2:    w_set_skip = 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Clear is applied before the step so a coincident step lands on +/-1
    assign w_pos_base = clear_pos ? '0 : position;

    // Tracker state, position, direction, step strobe and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_UNK;
            position    <= '0;
            dir         <= 1'b0;
            step_pulse  <= 1'b0;
            err_illegal <= 1'b0;
            err_skip    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            step_pulse <= w_step_fwd | w_step_rev;
            if (w_step_fwd) begin
                position <= w_pos_base + c_ONE;
            end else if (w_step_rev) begin
                position <= w_pos_base - c_ONE;
            end else begin
                position <= w_pos_base;
            end
            if (w_step_fwd | w_step_rev) begin
                dir <= w_step_fwd;
            end
            err_illegal <= (err_illegal & ~clear_err) | w_set_illegal;
            err_skip    <= (err_skip & ~clear_err) | w_set_skip;
        end
    end

    // Quiet-time counter and "stepped since last idle" flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= c_IDLE_MAX;
            r_stepped  <= 1'b0;
        end else begin
            if (r_chg) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != c_IDLE_MAX) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
            if (w_step_fwd | w_step_rev) begin
                r_stepped <= 1'b1;
            end else if (idle) begin
                r_stepped <= 1'b0;
            end
        end
    end

    assign idle   = (r_idle_cnt == c_IDLE_MAX);
    assign moving = r_stepped & ~idle;

endmodule
`default_nettype wire

// File: tb/tb_step_phase_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_phase_decoder
// Description : Self-checking bench for step_phase_decoder: directed test-plan
//               sequences with literal expectations plus a randomized phase
//               walk, all checked every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_phase_decoder;

    localparam int PW = 4;
    localparam int FC = 4;
    localparam int IC = 300;

    localparam logic [3:0] OFF = 4'b0000;
    localparam logic [3:0] P1  = 4'b1100;
    localparam logic [3:0] P2  = 4'b0110;
    localparam logic [3:0] P3  = 4'b0011;
    localparam logic [3:0] P4  = 4'b1001;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [3:0]           pins;
    logic                 clear_pos;
    logic                 clear_err;
    logic signed [PW-1:0] position;
    logic                 dir;
    logic                 step_pulse;
    logic                 moving;
    logic                 idle;
    logic                 err_illegal;
    logic                 err_skip;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int apply_edge = 0;
    int last_pulse_edge = -1;
    int pulse_cnt = 0;

    // Behavioural model state
    int         m_pos;
    bit         m_dir, m_pulse, m_ill, m_skip, m_flag;
    int         m_idle_cnt;
    int         m_last;          // last phase index 0..3, -1 when unknown/off
    logic [3:0] m_acc;
    bit         m_pending;
    logic [3:0] samp[$];         // samp[0] = pins seen at the latest edge

    step_phase_decoder #(
        .POS_W       (PW),
        .FILT_CYCLES (FC),
        .IDLE_CYCLES (IC)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .A1          (pins[3]),
        .B1          (pins[2]),
        .A2          (pins[1]),
        .B2          (pins[0]),
        .clear_pos   (clear_pos),
        .clear_err   (clear_err),
        .position    (position),
        .dir         (dir),
        .step_pulse  (step_pulse),
        .moving      (moving),
        .idle        (idle),
        .err_illegal (err_illegal),
        .err_skip    (err_skip)
    );

    always #5 clk = ~clk;

    function automatic int phase_of(logic [3:0] c);
        case (c)
            P1:      return 0;
            P2:      return 1;
            P3:      return 2;
            P4:      return 3;
            default: return -1;
        endcase
    endfunction

    function automatic bit is_legal(logic [3:0] c);
        return (c == OFF) || (phase_of(c) >= 0);
    endfunction

    function automatic int wrap(int x);
        int span = 1 << PW;
        int y = ((x % span) + span) % span;
        return (y >= span / 2) ? y - span : y;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_dir = 0; m_pulse = 0; m_ill = 0; m_skip = 0; m_flag = 0;
        m_idle_cnt = IC; m_last = -1; m_acc = OFF; m_pending = 0;
        samp.delete();
        for (int j = 0; j < FC + 2; j++) samp.push_back(4'b0000);
    endtask

    // One clock edge of the specified behaviour: act on a change accepted at the
    // previous edge, then decide whether the last FC synchronized samples agree.
    task automatic model_step();
        bit idle_before = (m_idle_cnt == IC);
        bit same = 1;
        int idx;
        int d;
        if (clear_pos) m_pos = 0;
        if (clear_err) begin m_ill = 0; m_skip = 0; end
        m_pulse = 0;
        if (m_pending) begin
            m_idle_cnt = 0;
            idx = phase_of(m_acc);
            if (m_acc == OFF) begin
                m_last = -1;
            end else if (idx < 0) begin
                m_ill = 1; m_last = -1;
            end else begin
                if (m_last >= 0) begin
                    d = (idx - m_last + 4) % 4;
                    if (d == 1) begin m_pos = m_pos + 1; m_dir = 1; m_pulse = 1; end
                    else if (d == 3) begin m_pos = m_pos - 1; m_dir = 0; m_pulse = 1; end
                    else if (d == 2) m_skip = 1;
                end
                m_last = idx;
            end
        end else if (m_idle_cnt < IC) begin
            m_idle_cnt++;
        end
        m_pos = wrap(m_pos);
        if (m_pulse) m_flag = 1;
        else if (idle_before) m_flag = 0;
        // Two synchronizer stages: the filter sees samp[2] as its newest sample
        samp.push_front(pins);
        void'(samp.pop_back());
        m_pending = 0;
        for (int j = 3; j <= FC + 1; j++) if (samp[j] !== samp[2]) same = 0;
        if (same && samp[2] !== m_acc) begin
            m_acc = samp[2];
            m_pending = 1;
        end
    endtask

    // Model process
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        @(negedge clk);
        chk("position", longint'(position), longint'(m_pos));
        chk("dir", dir, m_dir);
        chk("step_pulse", step_pulse, m_pulse);
        chk("idle", idle, m_idle_cnt == IC);
        chk("moving", moving, m_flag && (m_idle_cnt != IC));
        chk("err_illegal", err_illegal, m_ill);
        chk("err_skip", err_skip, m_skip);
        if (step_pulse === 1'b1) begin
            pulse_cnt++;
            last_pulse_edge = cyc;
        end
    end

    task automatic drive(input logic [3:0] code, input int n);
        pins = code;
        apply_edge = cyc + 1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_rand(input logic [3:0] code, input int n);
        pins = code;
        for (int k = 0; k < n; k++) begin
            clear_pos = ($urandom_range(0, 19) == 0);
            clear_err = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        clear_pos = 0;
        clear_err = 0;
    endtask

    task automatic pulse_clear_err();
        clear_err = 1;
        @(negedge clk);
        clear_err = 0;
    endtask

    task automatic wait_idle(input int bound, output int edge_seen);
        edge_seen = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (idle) begin
                edge_seen = cyc;
                break;
            end
        end
    endtask

    initial begin
        #5_000_000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Stimulus
    initial begin
        int         p0, e_idle, r, hold, s_idx, gl;
        logic [3:0] code;
        reset = 1; pins = OFF; clear_pos = 0; clear_err = 0;
        repeat (3) @(negedge clk);
        chk("rst_position", longint'(position), 0);
        chk("rst_idle", idle, 1);
        chk("rst_moving", moving, 0);
        chk("rst_errs", {err_illegal, err_skip}, 0);
        reset = 0;
        drive(OFF, 10);

        // Forward walk; the first phase after reset is only a reference point
        p0 = pulse_cnt;
        drive(P1, 50);
        drive(P2, 50);
        chk("lat_p2", last_pulse_edge - apply_edge, 6);
        drive(P3, 50);
        drive(P4, 50);
        drive(P1, 50);
        chk("lat_p1", last_pulse_edge - apply_edge, 6);
        chk("fwd_pos", longint'(position), 4);
        chk("fwd_dir", dir, 1);
        chk("fwd_pulses", pulse_cnt - p0, 4);

        // Reverse walk
        p0 = pulse_cnt;
        drive(P4, 50);
        drive(P3, 50);
        chk("rev_pos", longint'(position), 2);
        chk("rev_dir", dir, 0);
        chk("rev_pulses", pulse_cnt - p0, 2);
        chk("rev_errs", {err_illegal, err_skip}, 0);

        // Glitches shorter than the filter do not count or restart the idle timer
        drive(P4, 50);
        drive(P1, 50);
        drive(P2, 1);
        drive(P1, 10);
        drive(P2, 3);
        drive(P1, 10);
        chk("glitch_pos", longint'(position), 4);
        wait_idle(IC + 20, e_idle);
        chk("glitch_idle_edge", e_idle - last_pulse_edge, IC);
        drive(P2, 4);
        drive(OFF, 50);
        chk("hold4_pos", longint'(position), 5);

        // No step is inferred across OFF
        drive(P1, 50);
        drive(OFF, 50);
        drive(P2, 50);
        chk("off_pos", longint'(position), 5);
        drive(P4, 50);
        chk("skip_flag", err_skip, 1);
        chk("skip_pos", longint'(position), 5);
        pulse_clear_err();
        chk("skip_clear", err_skip, 0);

        // Illegal code, then tracking restarts
        drive(4'b1111, 50);
        chk("ill_flag", err_illegal, 1);
        chk("ill_pos", longint'(position), 5);
        drive(P3, 50);
        chk("ill_p3_pos", longint'(position), 5);
        drive(P4, 50);
        chk("ill_p4_pos", longint'(position), 6);
        pulse_clear_err();
        chk("ill_clear", err_illegal, 0);

        // Asynchronous reset in the middle of a move
        drive(P1, 20);
        drive(P2, 3);
        #3 reset = 1;
        #1;
        chk("arst_position", longint'(position), 0);
        chk("arst_idle", idle, 1);
        chk("arst_pulse", step_pulse, 0);
        @(negedge clk);
        reset = 0;
        drive(P2, 30);
        chk("arst_first_phase", longint'(position), 0);
        drive(P3, 30);
        chk("arst_next_phase", longint'(position), 1);

        // Wrap of the 4-bit counter
        clear_pos = 1;
        @(negedge clk);
        clear_pos = 0;
        chk("clear_pos", longint'(position), 0);
        drive(P4, 20); drive(P1, 20); drive(P2, 20); drive(P3, 20);
        drive(P4, 20); drive(P1, 20); drive(P2, 20); drive(P3, 20);
        chk("wrap_pos", longint'(position), -8);
        wait_idle(IC + 20, e_idle);
        chk("wrap_idle", idle, 1);
        chk("wrap_moving", moving, 0);

        // clear_pos on the same edge as a forward step
        pins = P4;
        repeat (6) @(negedge clk);
        clear_pos = 1;
        @(negedge clk);
        clear_pos = 0;
        chk("coinc_pulse", step_pulse, 1);
        chk("coinc_pos", longint'(position), 1);
        drive(P4, 20);

        // Randomized phase walk with glitches, skips, OFF, illegal codes, clears, resets
        s_idx = 3;
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            hold = ($urandom_range(0, 99) < 3) ? IC + 10 : $urandom_range(1, 12);
            if (r < 35) begin
                s_idx = (s_idx + 1) % 4;
                code = 4'(P1 >> 0);
            end else if (r < 60) begin
                s_idx = (s_idx + 3) % 4;
            end else if (r < 68) begin
                s_idx = (s_idx + 2) % 4;
            end
            case (s_idx)
                0:       code = P1;
                1:       code = P2;
                2:       code = P3;
                default: code = P4;
            endcase
            if (r >= 68 && r < 76) begin
                code = OFF;
            end else if (r >= 76 && r < 82) begin
                do code = 4'($urandom_range(0, 15)); while (is_legal(code));
            end else if (r >= 82 && r < 90) begin
                gl = $urandom_range(1, FC - 1);
                drive_rand(4'($urandom_range(0, 15)), gl);
            end
            drive_rand(code, hold);
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1;
                @(negedge clk);
                reset = 0;
            end
        end
        drive(pins, 20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
